// File: rtl/seq_pkg.sv
// Shared types and instruction-field definitions for the sequencer, disassembler and trace monitor.
package seq_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    FETCH_EXT = 3'd1,
    ISSUE     = 3'd2,
    EXEC      = 3'd3,
    HALT      = 3'd4
  } seq_state_e;

  localparam logic [1:0] CAT_IMM = 2'b00;
  localparam logic [1:0] CAT_REG = 2'b01;
  localparam logic [1:0] CAT_MEM = 2'b10;
  localparam logic [1:0] CAT_LIT = 2'b11;

  localparam logic [4:0] OP_LRLI = 5'b00010;
  localparam logic [4:0] OP_CALL = 5'b01110;

  localparam int CAT_HI = 15;
  localparam int CAT_LO = 14;
  localparam int OP_HI  = 13;
  localparam int OP_LO  = 9;
  localparam int DA_HI  = 8;
  localparam int DA_LO  = 6;
  localparam int AA_HI  = 5;
  localparam int AA_LO  = 3;
  localparam int BA_HI  = 2;
  localparam int BA_LO  = 0;

endpackage

// File: rtl/instr_seq_ctrl_if.sv
// Fetch/issue/execute bus between the sequence controller (master) and ROM + datapath (slave).
interface instr_seq_ctrl_if #(
  parameter int PC_W = 8,
  parameter int IW   = 16
);
  logic [PC_W-1:0] rom_addr;
  logic [IW-1:0]   rom_data;
  logic            issue_valid;
  logic            issue_ready;
  logic [IW-1:0]   ir;
  logic [IW-1:0]   ext_word;
  logic            ext_valid;
  logic            exec_done;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_target;
  logic            halt_req;
  logic            halted;
  logic [15:0]     instr_count;

  modport master (
    output rom_addr, issue_valid, ir, ext_word, ext_valid, halted, instr_count,
    input  rom_data, issue_ready, exec_done, redirect_valid, redirect_target, halt_req
  );

  modport slave (
    input  rom_addr, issue_valid, ir, ext_word, ext_valid, halted, instr_count,
    output rom_data, issue_ready, exec_done, redirect_valid, redirect_target, halt_req
  );
endinterface

// File: rtl/instr_len_decode.sv
// Combinational instruction-length decoder: flags words that carry a trailing extension word.
module instr_len_decode
  import seq_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic [IW-1:0] i_instr,
  output logic          o_is_two_word
);
  logic [1:0] w_cat;
  logic [4:0] w_op;
  logic       w_unused_fields;

  assign w_cat = i_instr[CAT_HI:CAT_LO];
  assign w_op  = i_instr[OP_HI:OP_LO];
  // Register-address fields and any bits above 16 play no part in length.
  assign w_unused_fields = ^{i_instr[IW-1:CAT_HI], i_instr[DA_HI:BA_LO]};

  assign o_is_two_word = (w_cat == CAT_MEM) && ((w_op == OP_LRLI) || (w_op == OP_CALL));
endmodule

// File: rtl/instr_seq_ctrl.sv
// Instruction fetch/sequence controller: owns the PC, assembles 1/2-word instructions, issues, applies redirects.
// Define SEQ_PERF_CNT_EN to build the retired-instruction counter; otherwise instr_count reads 0.
module instr_seq_ctrl
  import seq_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              IW       = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst_n,
  instr_seq_ctrl_if.master  bus
);
  seq_state_e      r_state, w_next;
  logic [PC_W-1:0] r_pc;
  logic [IW-1:0]   r_ir, r_ext;
  logic            r_ext_valid, r_issue_valid, r_halted;
  logic            w_two;

  instr_len_decode #(.IW(IW)) u_len (
    .i_instr       (bus.rom_data),
    .o_is_two_word (w_two)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FETCH:     if (bus.halt_req) w_next = HALT;
                 else              w_next = w_two ? FETCH_EXT : ISSUE;
      FETCH_EXT: w_next = ISSUE;
      ISSUE:     if (bus.issue_ready) w_next = EXEC;
      EXEC:      if (bus.exec_done) w_next = FETCH;
      HALT:      if (!bus.halt_req) w_next = FETCH;
      default:   w_next = FETCH;
    endcase
  end

  // issue_valid/halted are registered from the next state so they track ISSUE/HALT exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_ir          <= '0;
      r_ext         <= '0;
      r_ext_valid   <= 1'b0;
      r_issue_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_issue_valid <= (w_next == ISSUE);
      r_halted      <= (w_next == HALT);
      case (r_state)
        FETCH: if (!bus.halt_req) begin
          r_ir <= bus.rom_data;
          r_pc <= r_pc + 1'b1;
          if (!w_two) begin
            r_ext       <= '0;
            r_ext_valid <= 1'b0;
          end
        end
        FETCH_EXT: begin
          r_ext       <= bus.rom_data;
          r_ext_valid <= 1'b1;
          r_pc        <= r_pc + 1'b1;
        end
        EXEC: if (bus.exec_done && bus.redirect_valid) r_pc <= bus.redirect_target;
        default: ;
      endcase
    end
  end

  assign bus.rom_addr    = r_pc;
  assign bus.ir          = r_ir;
  assign bus.ext_word    = r_ext;
  assign bus.ext_valid   = r_ext_valid;
  assign bus.issue_valid = r_issue_valid;
  assign bus.halted      = r_halted;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] r_instr_cnt;
  logic        w_retire;

  assign w_retire = (r_state == EXEC) && bus.exec_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_instr_cnt <= 16'h0000;
    else if (w_retire && (r_instr_cnt != 16'hFFFF)) r_instr_cnt <= r_instr_cnt + 16'd1;
  end

  assign bus.instr_count = r_instr_cnt;
`else
  assign bus.instr_count = 16'h0000;
`endif
endmodule

// File: doc/instr_seq_ctrl.md
Name: instr_seq_ctrl

Overview:
Instruction fetch/sequence controller for the 16-bit processor. It owns the 8-bit PC and reads the combinational instruction ROM. It assembles one- or two-word instructions and hands each to the datapath through a valid/ready issue handshake. It then waits for execute completion and applies any branch/jump/call redirect returned by the datapath.

Parameters:
PC_W, 8, program counter / ROM address width
IW, 16, instruction word width
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rom_addr  out  PC_W  ROM address; always equals the PC register
rom_data  in  IW  ROM word for rom_addr, combinational and valid in the same cycle
issue_valid  out  1  ir/ext_word hold a complete instruction
issue_ready  in  1  datapath accepts the instruction
ir  out  IW  instruction word
ext_word  out  IW  second word of a two-word instruction; 0 otherwise
ext_valid  out  1  ext_word meaningful
exec_done  in  1  datapath finished the issued instruction (1-cycle pulse)
redirect_valid  in  1  qualified by exec_done: load the PC from redirect_target
redirect_target  in  PC_W  new PC
halt_req  in  1  level; stop fetching at the next instruction boundary
halted  out  1  controller is idle in HALT
instr_count  out  16  retired-instruction count (optional feature)

Behaviour:
- Reset (async assert, sync-safe deassert): PC=RESET_PC; state=FETCH; ir=0, ext_word=0, ext_valid=0, issue_valid=0, halted=0, instr_count=0.
- States: FETCH, FETCH_EXT, ISSUE, EXEC, HALT.
- FETCH:
  - If halt_req=1: go to HALT; PC is unchanged.
  - Otherwise: ir<=rom_data; PC<=PC+1.
  - If the word is two-word, go to FETCH_EXT; otherwise clear ext_word/ext_valid and go to ISSUE.
- Two-word detect: rom_data[15:14]==2'b10 and rom_data[13:9] is LRLI (5'b00010) or CALL (5'b01110).
- FETCH_EXT: ext_word<=rom_data; ext_valid<=1; PC<=PC+1; go to ISSUE.
- ISSUE:
  - issue_valid=1. ir, ext_word and ext_valid must stay stable until issue_valid&&issue_ready.
  - On the handshake, go to EXEC.
  - issue_valid is a registered output: it is high in the ISSUE state only.
- EXEC:
  - Wait for exec_done.
  - On exec_done: if redirect_valid, PC<=redirect_target (otherwise PC keeps the already-incremented value). Increment instr_count, then go to FETCH.
  - exec_done is legal in the same cycle EXEC is entered. exec_done seen outside EXEC is ignored.
- HALT: halted=1; PC is held. When halt_req=0, go to FETCH. halt_req is only sampled in FETCH, so an in-flight instruction always completes.
- Minimum latency, single-word instruction with issue_ready=1 and immediate exec_done: FETCH, ISSUE, EXEC = 3 cycles per instruction. Two-word instructions take 4.
- PC arithmetic is modulo 2^PC_W: 8'hFF+1 = 8'h00, including between the two words of a two-word instruction.
- NOP (16'h0000) is issued like any other word; it gets no special handling.
- Mid-operation reset: all state is lost immediately. After rst_n rises, the first fetch comes from RESET_PC.
- instr_count saturates at 16'hFFFF.

Optional Feature:
SEQ_PERF_CNT_EN — when defined, instr_count counts retired instructions as specified above. When undefined, the counter register is not built and instr_count is tied to 16'h0000. The port remains present so the interface is identical in both builds.

Decomposition:
- Package seq_pkg holds:
  - state enum (FETCH, FETCH_EXT, ISSUE, EXEC, HALT);
  - category constants CAT_IMM=2'b00, CAT_REG=2'b01, CAT_MEM=2'b10, CAT_LIT=2'b11;
  - opcode constants OP_LRLI=5'b00010, OP_CALL=5'b01110;
  - the field slices [15:14] category, [13:9] opcode, [8:6] DA, [5:3] AA, [2:0] BA.
- One sub-module is natural: instr_len_decode, a combinational two-word detector (IW in → is_two_word out). It is reused later by the disassembler and the trace monitor.

Test Plan:
- Reset, sequential fetch: ROM words 0x400A, 0x404A, 0x408A at PC 0..2, issue_ready=1, exec_done one cycle after issue → ir sequence 0x400A, 0x404A, 0x408A; issue_valid high on cycles 1, 4, 7; PC=3; instr_count=3 with the macro.
- Two-word LRLI: PC=0x1E holds 0x844A, PC=0x1F holds 0x0001 → ir=0x844A, ext_word=0x0001, ext_valid=1; the next fetch is at PC=0x20.
- Issue backpressure: issue_ready=0 for 5 cycles → issue_valid stays 1 and ir is stable; a single EXEC entry follows the first ready cycle.
- Redirect: exec_done=1 with redirect_valid=1 and redirect_target=0x2D → the next rom_addr is 0x2D. exec_done with redirect_valid=0 → the PC continues sequentially.
- Halt and wrap: halt_req raised during EXEC → the instruction completes, then HALT with halted=1 and the PC held. Release halt at PC=0xFF with a single-word instruction → the next PC is 0x00.
- Reset mid-EXEC: assert rst_n=0 while in EXEC → outputs go to reset values immediately; after release, the fetch is from RESET_PC and instr_count=0.
